// File: rtl/conva_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : conva_wb_loader
// Purpose  : Streams conv-layer weights into each unit's weight memory in
//            turn, then the biases into the bias memory, driving the
//            datapath's RISC-V load port from a valid/ready word stream.
// Revision : 1.0 - initial release
// ============================================================================
module conva_wb_loader #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 15,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int IFM_DEPTH         = 16,
  parameter int NUMBER_OF_UNITS   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       load_abort,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      riscv_data,
  output logic [ADDRESS_BITS-1:0]    riscv_address,
  output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
  output logic                       bm_enable_write,
  output logic                       wm_addr_sel,
  output logic                       bm_addr_sel,
  output logic                       busy,
  output logic                       done
);

  // Each unit holds ceil(depth/units) input channels worth of kernels.
  localparam int DEPTH_PER_UNIT = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int WORDS_PER_UNIT = KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS * DEPTH_PER_UNIT;
  localparam int UNIT_BITS      = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;
  localparam int WORD_BITS      = (WORDS_PER_UNIT > 1) ? $clog2(WORDS_PER_UNIT) : 1;
  localparam int BIAS_BITS      = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;

  localparam logic [WORD_BITS-1:0] WORD_LAST = WORD_BITS'(WORDS_PER_UNIT - 1);
  localparam logic [UNIT_BITS-1:0] UNIT_LAST = UNIT_BITS'(NUMBER_OF_UNITS - 1);
  localparam logic [BIAS_BITS-1:0] BIAS_LAST = BIAS_BITS'(NUMBER_OF_FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_LOAD_B = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                     r_state;
  logic [WORD_BITS-1:0]       r_word_cnt;
  logic [UNIT_BITS-1:0]       r_unit_cnt;
  logic [BIAS_BITS-1:0]       r_bias_cnt;
  logic [NUMBER_OF_UNITS-1:0] w_unit_onehot;
  logic                       w_accept;

  // s_ready is only ever high in the two load states, so it doubles as the
  // "handshake allowed" qualifier.
  assign w_accept = s_valid && s_ready;

  // Decode the current unit into its weight-memory write strobe.
  generate
    for (genvar gi = 0; gi < NUMBER_OF_UNITS; gi++) begin : g_unit_onehot
      assign w_unit_onehot[gi] = (r_unit_cnt == UNIT_BITS'(gi));
    end
  endgenerate

  // Load sequencer: handshake, address counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_word_cnt      <= '0;
      r_unit_cnt      <= '0;
      r_bias_cnt      <= '0;
      s_ready         <= 1'b0;
      riscv_data      <= '0;
      riscv_address   <= '0;
      wm_enable_write <= '0;
      bm_enable_write <= 1'b0;
      wm_addr_sel     <= 1'b1;
      bm_addr_sel     <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // Strobes and done are single-cycle pulses unless re-armed below.
      wm_enable_write <= '0;
      bm_enable_write <= 1'b0;
      done            <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A start request outranks a coincident abort here.
          if (load_start) begin
            r_state     <= S_LOAD_W;
            r_word_cnt  <= '0;
            r_unit_cnt  <= '0;
            r_bias_cnt  <= '0;
            s_ready     <= 1'b1;
            busy        <= 1'b1;
            wm_addr_sel <= 1'b0;
            bm_addr_sel <= 1'b0;
          end
        end

        S_LOAD_W: begin
          if (load_abort) begin
            // Any beat taken this cycle is dropped without a write.
            r_state     <= S_IDLE;
            r_word_cnt  <= '0;
            r_unit_cnt  <= '0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            wm_addr_sel <= 1'b1;
            bm_addr_sel <= 1'b1;
          end else if (w_accept) begin
            riscv_data      <= s_data;
            riscv_address   <= ADDRESS_BITS'(r_word_cnt);
            wm_enable_write <= w_unit_onehot;
            if (r_word_cnt == WORD_LAST) begin
              r_word_cnt <= '0;
              if (r_unit_cnt == UNIT_LAST) begin
                // Ready stays high so the first bias beat follows directly.
                r_unit_cnt <= '0;
                r_bias_cnt <= '0;
                r_state    <= S_LOAD_B;
              end else begin
                r_unit_cnt <= r_unit_cnt + 1'b1;
              end
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end

        S_LOAD_B: begin
          if (load_abort) begin
            r_state     <= S_IDLE;
            r_bias_cnt  <= '0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            wm_addr_sel <= 1'b1;
            bm_addr_sel <= 1'b1;
          end else if (w_accept) begin
            riscv_data      <= s_data;
            riscv_address   <= ADDRESS_BITS'(r_bias_cnt);
            bm_enable_write <= 1'b1;
            if (r_bias_cnt == BIAS_LAST) begin
              // done coincides with the final bias write strobe.
              r_bias_cnt <= '0;
              r_state    <= S_DONE;
              s_ready    <= 1'b0;
              done       <= 1'b1;
            end else begin
              r_bias_cnt <= r_bias_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          // Hand the memory address muxes back to the datapath.
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          wm_addr_sel <= 1'b1;
          bm_addr_sel <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conva_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conva_wb_loader
// Purpose  : Self-checking bench for conva_wb_loader. A small configuration
//            (K=2 F=3 D=4 U=2) is compared cycle by cycle against a
//            transaction-level model; a default configuration checks the
//            full-size address sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conva_wb_loader;

  localparam int W     = 24;          // 2*2*3*ceil(4/2)
  localparam int U     = 2;
  localparam int F     = 3;
  localparam int TOTAL = U * W + F;   // 51

  localparam int DW     = 18000;      // 5*5*120*ceil(16/3)
  localparam int DU     = 3;
  localparam int DF     = 120;
  localparam int DTOTAL = DU * DW + DF;

  // {ready, wm[1:0], bm, wsel, bsel, busy, done, addr[14:0], data[31:0]}
  localparam logic [54:0] RESET_VEC = 55'h6_0000_0000_0000;

  logic clk;
  logic reset;

  // Small DUT
  logic        load_start, load_abort, s_valid, s_ready;
  logic [31:0] s_data, riscv_data;
  logic [14:0] riscv_address;
  logic [1:0]  wm_enable_write;
  logic        bm_enable_write, wm_addr_sel, bm_addr_sel, busy, done;

  // Default-size DUT
  logic        d_load_start, d_load_abort, d_s_valid, d_s_ready;
  logic [31:0] d_s_data, d_riscv_data;
  logic [14:0] d_riscv_address;
  logic [2:0]  d_wm_enable_write;
  logic        d_bm_enable_write, d_wm_addr_sel, d_bm_addr_sel, d_busy, d_done;

  int n_vec = 0;
  int n_err = 0;

  conva_wb_loader #(
    .DATA_WIDTH(32), .ADDRESS_BITS(15), .KERNAL_SIZE(2),
    .NUMBER_OF_FILTERS(3), .IFM_DEPTH(4), .NUMBER_OF_UNITS(2)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_abort(load_abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .riscv_data(riscv_data), .riscv_address(riscv_address),
    .wm_enable_write(wm_enable_write), .bm_enable_write(bm_enable_write),
    .wm_addr_sel(wm_addr_sel), .bm_addr_sel(bm_addr_sel),
    .busy(busy), .done(done)
  );

  conva_wb_loader dut_def (
    .clk(clk), .reset(reset), .load_start(d_load_start), .load_abort(d_load_abort),
    .s_data(d_s_data), .s_valid(d_s_valid), .s_ready(d_s_ready),
    .riscv_data(d_riscv_data), .riscv_address(d_riscv_address),
    .wm_enable_write(d_wm_enable_write), .bm_enable_write(d_bm_enable_write),
    .wm_addr_sel(d_wm_addr_sel), .bm_addr_sel(d_bm_addr_sel),
    .busy(d_busy), .done(d_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 = idle, 1 = loading, 2 = done cycle
  int          m_phase;
  int          m_n;        // beats written so far in this load
  logic        e_ready, e_bm, e_wsel, e_bsel, e_busy, e_done;
  logic [1:0]  e_wm;
  logic [14:0] e_addr;
  logic [31:0] e_data;

  logic [54:0] obs, exp_vec;
  assign obs     = {s_ready, wm_enable_write, bm_enable_write, wm_addr_sel, bm_addr_sel,
                    busy, done, riscv_address, riscv_data};
  assign exp_vec = {e_ready, e_wm, e_bm, e_wsel, e_bsel, e_busy, e_done, e_addr, e_data};

  task automatic model_reset();
    m_phase = 0; m_n = 0;
    e_ready = 0; e_wm = 0; e_bm = 0; e_wsel = 1; e_bsel = 1;
    e_busy = 0; e_done = 0; e_addr = 0; e_data = 0;
  endtask

  // Word n of a load goes to unit n/W at address n%W; the remaining F words
  // go to the bias memory.
  task automatic model_edge(input logic st, input logic ab, input logic vl,
                            input logic [31:0] dt);
    e_wm = 0; e_bm = 0; e_done = 0;
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1; m_n = 0;
        e_ready = 1; e_busy = 1; e_wsel = 0; e_bsel = 0;
      end
    end else if (m_phase == 1) begin
      if (ab) begin
        m_phase = 0;
        e_ready = 0; e_busy = 0; e_wsel = 1; e_bsel = 1;
      end else if (vl) begin
        e_data = dt;
        if (m_n < U * W) begin
          e_addr = 15'(m_n % W);
          e_wm   = 2'(1 << (m_n / W));
        end else begin
          e_addr = 15'(m_n - U * W);
          e_bm   = 1;
        end
        m_n++;
        if (m_n == TOTAL) begin
          m_phase = 2; e_done = 1; e_ready = 0;
        end
      end
    end else begin
      m_phase = 0;
      e_busy = 0; e_wsel = 1; e_bsel = 1;
    end
  endtask

  // One clock of the small DUT: drive inputs, advance, update model, settle.
  task automatic cyc(input logic st, input logic ab, input logic vl, input logic [31:0] dt);
    load_start = st; load_abort = ab; s_valid = vl; s_data = dt;
    @(posedge clk);
    model_edge(st, ab, vl, dt);
    #1;
    load_start = 0; load_abort = 0; s_valid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (obs !== RESET_VEC) begin
      n_err++; $display("FAIL reset_values got=%h exp=%h", obs, RESET_VEC);
    end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, $urandom);
      n_vec++;
      if (obs !== RESET_VEC || obs !== exp_vec) begin
        n_err++; $display("FAIL idle_ignores_valid cyc=%0d got=%h exp=%h", i, obs, RESET_VEC);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0);
    n_vec++;
    if (obs !== exp_vec) begin
      n_err++; $display("FAIL b2b_start got=%h exp=%h", obs, exp_vec);
    end
    for (int i = 0; i < TOTAL + 2; i++) begin
      cyc(0, 0, i < TOTAL, 32'h100 + 32'(i));
      n_vec++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL b2b_write cyc=%0d got=%h exp=%h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_toggle_valid();
    int writes = 0;
    int cnt = 0;
    cyc(1, 0, 0, 0);
    while (m_phase != 0 && cnt < 300) begin
      cyc(0, 0, cnt[0] == 1'b0, $urandom);
      if (|wm_enable_write || bm_enable_write) writes++;
      n_vec++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL toggle_write cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
      end
      cnt++;
    end
    n_vec++;
    if (m_phase != 0 || writes != TOTAL) begin
      n_err++; $display("FAIL toggle_write_count got=%0d exp=%0d", writes, TOTAL);
    end
  endtask

  task automatic test_abort();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, $urandom);
    cyc(0, 1, 1, $urandom);
    n_vec++;
    if (obs !== exp_vec || done !== 1'b0 || wm_addr_sel !== 1'b1) begin
      n_err++; $display("FAIL abort_idle got=%h exp=%h", obs, exp_vec);
    end
    cyc(0, 0, 1, $urandom);
    n_vec++;
    if (obs !== exp_vec) begin
      n_err++; $display("FAIL abort_stays_idle got=%h exp=%h", obs, exp_vec);
    end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, $urandom);
      n_vec++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", i, obs, exp_vec);
      end
    end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_start_ignored();
    int cnt = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, $urandom);
    cyc(1, 0, 1, $urandom);
    n_vec++;
    if (obs !== exp_vec) begin
      n_err++; $display("FAIL start_mid_load got=%h exp=%h", obs, exp_vec);
    end
    while (m_phase != 0 && cnt < 400) begin
      cyc(0, 0, $urandom_range(0, 3) != 0, $urandom);
      n_vec++;
      if (obs !== exp_vec) begin
        n_err++; $display("FAIL start_ignored_run cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
      end
      cnt++;
    end
    n_vec++;
    if (m_phase != 0) begin
      n_err++; $display("FAIL start_ignored_timeout got=%0d exp=%0d", cnt, 400);
    end
  endtask

  task automatic test_reset_in_bias();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < U * W + 1; i++) cyc(0, 0, 1, $urandom);
    n_vec++;
    if (obs !== exp_vec || bm_enable_write !== 1'b1) begin
      n_err++; $display("FAIL reach_bias got=%h exp=%h", obs, exp_vec);
    end
    reset = 0;
    #1;
    n_vec++;
    if (obs !== RESET_VEC) begin
      n_err++; $display("FAIL async_reset got=%h exp=%h", obs, RESET_VEC);
    end
    model_reset();
    @(posedge clk); #2;
    reset = 1;
    cyc(0, 0, 1, $urandom);
    n_vec++;
    if (obs !== exp_vec) begin
      n_err++; $display("FAIL after_reset got=%h exp=%h", obs, exp_vec);
    end
  endtask

  task automatic test_defaults();
    logic [2:0]  ewm;
    logic        ebm;
    logic [14:0] eaddr;
    logic [31:0] dt;
    d_load_start = 1;
    @(posedge clk); #1;
    d_load_start = 0;
    n_vec++;
    if ({d_s_ready, d_busy, d_wm_addr_sel, d_bm_addr_sel} !== 4'b1100) begin
      n_err++; $display("FAIL def_start got=%b exp=%b",
                        {d_s_ready, d_busy, d_wm_addr_sel, d_bm_addr_sel}, 4'b1100);
    end
    for (int n = 0; n < DTOTAL; n++) begin
      dt = $urandom;
      d_s_valid = 1; d_s_data = dt;
      @(posedge clk); #1;
      if (n < DU * DW) begin
        ewm = 3'(1 << (n / DW)); ebm = 0; eaddr = 15'(n % DW);
      end else begin
        ewm = 0; ebm = 1; eaddr = 15'(n - DU * DW);
      end
      n_vec++;
      if ({d_wm_enable_write, d_bm_enable_write, d_riscv_address, d_riscv_data,
           d_done, d_s_ready} !== {ewm, ebm, eaddr, dt, n == DTOTAL - 1, n != DTOTAL - 1}) begin
        n_err++; $display("FAIL def_write n=%0d got=%b_%b_%0d_%h exp=%b_%b_%0d_%h", n,
                          d_wm_enable_write, d_bm_enable_write, d_riscv_address, d_riscv_data,
                          ewm, ebm, eaddr, dt);
      end
      if (n == DU * DW - 1) begin
        n_vec++;
        if ({d_wm_enable_write, d_riscv_address} !== {3'b100, 15'd17999}) begin
          n_err++; $display("FAIL def_last_weight got=%b_%0d exp=100_17999",
                            d_wm_enable_write, d_riscv_address);
        end
      end
    end
    d_s_valid = 0;
    @(posedge clk); #1;
    n_vec++;
    if ({d_busy, d_done, d_wm_addr_sel, d_bm_addr_sel, d_wm_enable_write, d_bm_enable_write}
        !== 8'b0011_0000) begin
      n_err++; $display("FAIL def_idle got=%b exp=%b",
                        {d_busy, d_done, d_wm_addr_sel, d_bm_addr_sel, d_wm_enable_write,
                         d_bm_enable_write}, 8'b0011_0000);
    end
  endtask

  initial begin
    reset = 1; load_start = 0; load_abort = 0; s_valid = 0; s_data = 0;
    d_load_start = 0; d_load_abort = 0; d_s_valid = 0; d_s_data = 0;
    model_reset();
    #2;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_abort();
    test_start_ignored();
    test_reset_in_bias();
    test_defaults();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
